// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-style main control unit:
// FSM states, opcode map, ALU control codes and the decoded-instruction record.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR
   } state_t;

   typedef enum logic [2:0] {
      C_RTYPE, C_LDI, C_LD, C_ST, C_BEQ, C_BNE, C_JMP, C_HALT
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LDI   = 6'h01;
   localparam logic [5:0] OP_LD    = 6'h02;
   localparam logic [5:0] OP_ST    = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_JMP   = 6'h06;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   localparam logic [1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [1:0] ALUOP_LDI   = 2'b01;
   localparam logic [1:0] ALUOP_BNE   = 2'b10;
   localparam logic [1:0] ALUOP_ADDR  = 2'b11;

   // Valid ALU operations span 000000..001011; anything above is not an ALU function.
   localparam logic [5:0] ALU_OP_NOP = 6'b000000;
   localparam logic [5:0] ALU_OP_ADD = 6'b000001;
   localparam logic [5:0] ALU_OP_SUB = 6'b000010;
   localparam logic [5:0] ALU_OP_MAX = 6'b001011;

   localparam logic [1:0] PC_INC    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   typedef struct packed {
      iclass_t    cls;
      logic [5:0] operation;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       illegal;
   } decode_t;

endpackage

// File: rtl/mc_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The control unit is the master:
// it drives every strobe and ALU control, and consumes memory data/ack and the ALU zero flag.
interface mc_control_unit_if #(
   parameter int RETIRE_W = 16
);
   logic [31:0]         instruction;
   logic                memReady;
   logic                zero;
   logic                memReq;
   logic                memWrite;
   logic                iorD;
   logic                irWrite;
   logic [5:0]          operation;
   logic [1:0]          ALUOp;
   logic                aluSrc;
   logic                regWrite;
   logic                memToReg;
   logic                pcWrite;
   logic [1:0]          pcSrc;
   logic                halted;
   logic                illegal;
   logic [RETIRE_W-1:0] retired;

   modport master (
      input  instruction, memReady, zero,
      output memReq, memWrite, iorD, irWrite, operation, ALUOp, aluSrc,
             regWrite, memToReg, pcWrite, pcSrc, halted, illegal, retired
   );

   modport slave (
      output instruction, memReady, zero,
      input  memReq, memWrite, iorD, irWrite, operation, ALUOp, aluSrc,
             regWrite, memToReg, pcWrite, pcSrc, halted, illegal, retired
   );
endinterface

// File: rtl/mc_opcode_decode.sv
// Combinational opcode/funct decoder: instruction class, ALU controls and illegal flag.
module mc_opcode_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output decode_t    dec
);

   always_comb begin
      dec = '0;
      case (opcode)
         OP_RTYPE: begin
            dec.cls       = C_RTYPE;
            dec.operation = funct;
            dec.alu_op    = ALUOP_FUNCT;
            dec.illegal   = (funct > ALU_OP_MAX);
         end
         OP_LDI: begin
            dec.cls     = C_LDI;
            dec.alu_op  = ALUOP_LDI;
            dec.alu_src = 1'b1;
         end
         OP_LD: begin
            dec.cls     = C_LD;
            dec.alu_op  = ALUOP_ADDR;
            dec.alu_src = 1'b1;
         end
         OP_ST: begin
            dec.cls     = C_ST;
            dec.alu_op  = ALUOP_ADDR;
            dec.alu_src = 1'b1;
         end
         OP_BEQ: begin
            dec.cls       = C_BEQ;
            dec.operation = ALU_OP_SUB;
            dec.alu_op    = ALUOP_FUNCT;
         end
         OP_BNE: begin
            dec.cls       = C_BNE;
            dec.operation = ALU_OP_SUB;
            dec.alu_op    = ALUOP_BNE;
         end
         OP_JMP:  dec.cls = C_JMP;
         OP_HALT: dec.cls = C_HALT;
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing,
// memory handshake, write enables and a wrapping instructions-retired counter.
module mc_control_unit
   import mc_ctrl_pkg::*;
#(
   parameter int RETIRE_W     = 16,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   mc_control_unit_if.master bus
);

   state_t              state, next;
   logic [5:0]          ir_op, ir_funct;
   decode_t             dec, dec_q;
   logic [RETIRE_W-1:0] retired_q;
   logic                retire;

   logic       mem_req, mem_write, iord, ir_write, alu_src;
   logic       reg_write, mem_to_reg, pc_write, halted, illegal;
   logic [5:0] operation;
   logic [1:0] alu_op, pc_src;

   // Only the opcode/funct fields are decoded; the rest belongs to the datapath.
   logic unused_instr;
   assign unused_instr = ^bus.instruction[25:6];

   mc_opcode_decode u_decode (
      .opcode (ir_op),
      .funct  (ir_funct),
      .dec    (dec)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= FETCH;
         ir_op     <= '0;
         ir_funct  <= '0;
         dec_q     <= '0;
         retired_q <= '0;
      end else begin
         state <= next;
         // Memory data is only valid in the handshake cycle, so keep our own copy.
         if (ir_write) begin
            ir_op    <= bus.instruction[31:26];
            ir_funct <= bus.instruction[5:0];
         end
         if (state == DECODE) dec_q <= dec;
         if (retire) retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   always_comb begin
      next       = state;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_INC;
      halted     = 1'b0;
      illegal    = 1'b0;
      operation  = ALU_OP_NOP;
      alu_op     = ALUOP_FUNCT;
      alu_src    = 1'b0;

      // ALU controls stay up from EXECUTE until the result has been consumed.
      if (state inside {EXECUTE, MEMORY, WRITEBACK}) begin
         operation = dec_q.operation;
         alu_op    = dec_q.alu_op;
         alu_src   = dec_q.alu_src;
      end

      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.memReady) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               next     = DECODE;
            end
         end
         DECODE: begin
            if (dec.illegal) begin
               if (ILLEGAL_HALT) next = ERROR;
               else begin
                  retire = 1'b1;
                  next   = FETCH;
               end
            end else if (dec.cls == C_HALT) next = HALT;
            else next = EXECUTE;
         end
         EXECUTE: begin
            case (dec_q.cls)
               C_BEQ, C_BNE: begin
                  // zero already reflects the bne inversion inside the ALU.
                  pc_src   = PC_BRANCH;
                  pc_write = bus.zero;
                  retire   = 1'b1;
                  next     = FETCH;
               end
               C_JMP: begin
                  pc_src   = PC_JUMP;
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  next     = FETCH;
               end
               C_LD, C_ST: next = MEMORY;
               default:    next = WRITEBACK;
            endcase
         end
         MEMORY: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_write = (dec_q.cls == C_ST);
            if (bus.memReady) begin
               if (dec_q.cls == C_ST) begin
                  retire = 1'b1;
                  next   = FETCH;
               end else next = WRITEBACK;
            end
         end
         WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = (dec_q.cls == C_LD);
            retire     = 1'b1;
            next       = FETCH;
         end
         HALT:    halted  = 1'b1;
         ERROR:   illegal = 1'b1;
         default: next    = FETCH;
      endcase
   end

   // A reset cycle must never let a transfer or a write enable escape.
   assign bus.memReq    = mem_req & reset;
   assign bus.memWrite  = mem_write;
   assign bus.iorD      = iord;
   assign bus.irWrite   = ir_write & reset;
   assign bus.operation = operation;
   assign bus.ALUOp     = alu_op;
   assign bus.aluSrc    = alu_src;
   assign bus.regWrite  = reg_write & reset;
   assign bus.memToReg  = mem_to_reg;
   assign bus.pcWrite   = pc_write & reset;
   assign bus.pcSrc     = pc_src;
   assign bus.halted    = halted;
   assign bus.illegal   = illegal;
   assign bus.retired   = retired_q;

endmodule
